// File: rtl/weight_update_sequencer.sv
// Sequencer for one neuron's weight update: streams old weights, data points and the
// latched delta into the float32 update unit, then writes each returned weight back.
module weight_update_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_INPUTS     = 32,
    parameter int unsigned WADDR_WIDTH    = 10,
    parameter int unsigned XADDR_WIDTH    = 6,
    parameter int unsigned ISSUE_INTERVAL = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [WADDR_WIDTH-1:0] i_base_addr,
    input  logic [DATA_WIDTH-1:0]  i_delta,
    output logic                   o_w_rd_en,
    output logic [WADDR_WIDTH-1:0] o_w_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_w_rd_data,
    output logic                   o_x_rd_en,
    output logic [XADDR_WIDTH-1:0] o_x_rd_addr,
    input  logic [DATA_WIDTH-1:0]  i_x_rd_data,
    output logic                   o_upd_valid,
    output logic [DATA_WIDTH-1:0]  o_upd_old_weight,
    output logic [DATA_WIDTH-1:0]  o_upd_data_point,
    output logic [DATA_WIDTH-1:0]  o_upd_delta,
    input  logic                   i_upd_valid,
    input  logic [DATA_WIDTH-1:0]  i_upd_new_weight,
    output logic                   o_w_wr_en,
    output logic [WADDR_WIDTH-1:0] o_w_wr_addr,
    output logic [DATA_WIDTH-1:0]  o_w_wr_data,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned CNT_W = $clog2(NUM_INPUTS + 2);
    localparam int unsigned GAP_W = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

    localparam logic [CNT_W-1:0]      LAST_K     = CNT_W'(NUM_INPUTS);
    localparam logic [CNT_W-1:0]      NUM_WORDS  = CNT_W'(NUM_INPUTS + 1);
    localparam logic [GAP_W-1:0]      GAP_RELOAD = GAP_W'(ISSUE_INTERVAL - 1);
    localparam logic [DATA_WIDTH-1:0] ONE_F32    = DATA_WIDTH'(32'h3F80_0000);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       k_q, k_d;
    logic [CNT_W-1:0]       j_q, j_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [WADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0]  delta_q, delta_d;
    logic                   w_rd_en_q, w_rd_en_d;
    logic [WADDR_WIDTH-1:0] w_rd_addr_q, w_rd_addr_d;
    logic                   x_rd_en_q, x_rd_en_d;
    logic [XADDR_WIDTH-1:0] x_rd_addr_q, x_rd_addr_d;
    logic                   upd_valid_q, upd_valid_d;
    logic                   upd_is_x_q, upd_is_x_d;
    logic                   wr_en_q, wr_en_d;
    logic [WADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   rd_now;
    logic [CNT_W-1:0]       rd_idx;
    logic [WADDR_WIDTH-1:0] rd_base;
    logic                   rd_bias;

    // Next-state, read pacing, writeback and registered-output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        j_d         = j_q;
        gap_d       = gap_q;
        base_d      = base_q;
        delta_d     = delta_q;
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = w_rd_addr_q;
        x_rd_en_d   = 1'b0;
        x_rd_addr_d = x_rd_addr_q;
        upd_valid_d = w_rd_en_q;
        upd_is_x_d  = x_rd_en_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_now      = 1'b0;
        rd_idx      = '0;
        rd_base     = base_q;
        rd_bias     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d  = i_base_addr;
                    delta_d = i_delta;
                    j_d     = '0;
                    k_d     = CNT_W'(1);
                    gap_d   = GAP_RELOAD;
                    rd_now  = 1'b1;
                    rd_idx  = '0;
                    rd_base = i_base_addr;
                    state_d = (LAST_K == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (gap_q == '0) begin
                    rd_now  = 1'b1;
                    rd_idx  = k_q;
                    k_d     = k_q + CNT_W'(1);
                    gap_d   = GAP_RELOAD;
                    if (k_q == LAST_K) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            S_DRAIN: begin
                if (wr_en_q && (j_q == NUM_WORDS)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The bias word has no data point, so only the weight RAM is read for it
        if (rd_now) begin
            rd_bias     = (rd_idx == LAST_K);
            w_rd_en_d   = 1'b1;
            w_rd_addr_d = rd_base + WADDR_WIDTH'(rd_idx);
            if (!rd_bias) begin
                x_rd_en_d   = 1'b1;
                x_rd_addr_d = XADDR_WIDTH'(rd_idx);
            end
        end

        // Results return in order, so the j-th result belongs to base + j
        if (((state_q == S_ISSUE) || (state_q == S_DRAIN)) && i_upd_valid && (j_q != NUM_WORDS)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = base_q + WADDR_WIDTH'(j_q);
            wr_data_d = i_upd_new_weight;
            j_d       = j_q + CNT_W'(1);
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            j_q         <= '0;
            gap_q       <= '0;
            base_q      <= '0;
            delta_q     <= '0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            x_rd_en_q   <= 1'b0;
            x_rd_addr_q <= '0;
            upd_valid_q <= 1'b0;
            upd_is_x_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            j_q         <= j_d;
            gap_q       <= gap_d;
            base_q      <= base_d;
            delta_q     <= delta_d;
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            x_rd_en_q   <= x_rd_en_d;
            x_rd_addr_q <= x_rd_addr_d;
            upd_valid_q <= upd_valid_d;
            upd_is_x_q  <= upd_is_x_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_w_rd_en   = w_rd_en_q;
    assign o_w_rd_addr = w_rd_addr_q;
    assign o_x_rd_en   = x_rd_en_q;
    assign o_x_rd_addr = x_rd_addr_q;
    assign o_upd_valid = upd_valid_q;
    assign o_upd_delta = delta_q;
    assign o_w_wr_en   = wr_en_q;
    assign o_w_wr_addr = wr_addr_q;
    assign o_w_wr_data = wr_data_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    // RAM read data passes straight to the update unit in the issue cycle; quiet otherwise
    assign o_upd_old_weight = upd_valid_q ? i_w_rd_data : '0;
    assign o_upd_data_point = upd_valid_q ? (upd_is_x_q ? i_x_rd_data : ONE_F32) : '0;

endmodule

// File: tb/tb_weight_update_sequencer.sv
// Bench for weight_update_sequencer: RAM models, a fixed-latency update-unit model and a
// scoreboard of expected reads, issues, writebacks and done pulses.
module tb_weight_update_sequencer;

    typedef struct { int u; int c; logic [9:0] a; logic xen; logic [5:0] xa; } rd_t;
    typedef struct { int u; int c; logic [31:0] ow; logic [31:0] xv; logic [31:0] dv; } iss_t;
    typedef struct { int u; int c; logic [9:0] a; logic [31:0] dv; } wr_t;
    typedef struct { int u; int c; } dn_t;
    typedef struct { int u; int due; logic [31:0] val; } pend_t;

    logic        clk;
    logic        rst;
    logic        start_s   [2];
    logic [9:0]  base_s    [2];
    logic [31:0] delta_s   [2];
    logic        w_rd_en   [2];
    logic [9:0]  w_rd_addr [2];
    logic [31:0] w_rd_data [2];
    logic        x_rd_en   [2];
    logic [5:0]  x_rd_addr [2];
    logic [31:0] x_rd_data [2];
    logic        upd_v     [2];
    logic [31:0] upd_old   [2];
    logic [31:0] upd_x     [2];
    logic [31:0] upd_d     [2];
    logic        res_v     [2];
    logic [31:0] res_w     [2];
    logic        wr_en     [2];
    logic [9:0]  wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic        busy      [2];
    logic        done      [2];

    logic [31:0] wmem [1024];
    logic [31:0] xmem [64];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   [2];
    int done_cnt [2];

    rd_t   exp_rd[$];
    iss_t  exp_iss[$];
    wr_t   exp_wr[$];
    dn_t   exp_dn[$];
    pend_t pend[$];
    logic [9:0]  obs_wa[$];
    logic [31:0] obs_wd[$];

    // Instance 0: slow pacing; instance 1: back-to-back issue
    for (genvar g = 0; g < 2; g++) begin : g_dut
        weight_update_sequencer #(
            .DATA_WIDTH    (32),
            .NUM_INPUTS    ((g == 0) ? 2 : 4),
            .WADDR_WIDTH   (10),
            .XADDR_WIDTH   (6),
            .ISSUE_INTERVAL((g == 0) ? 21 : 1)
        ) dut (
            .clk             (clk),
            .rst             (rst),
            .i_start         (start_s[g]),
            .i_base_addr     (base_s[g]),
            .i_delta         (delta_s[g]),
            .o_w_rd_en       (w_rd_en[g]),
            .o_w_rd_addr     (w_rd_addr[g]),
            .i_w_rd_data     (w_rd_data[g]),
            .o_x_rd_en       (x_rd_en[g]),
            .o_x_rd_addr     (x_rd_addr[g]),
            .i_x_rd_data     (x_rd_data[g]),
            .o_upd_valid     (upd_v[g]),
            .o_upd_old_weight(upd_old[g]),
            .o_upd_data_point(upd_x[g]),
            .o_upd_delta     (upd_d[g]),
            .i_upd_valid     (res_v[g]),
            .i_upd_new_weight(res_w[g]),
            .o_w_wr_en       (wr_en[g]),
            .o_w_wr_addr     (wr_addr[g]),
            .o_w_wr_data     (wr_data[g]),
            .o_busy          (busy[g]),
            .o_done          (done[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and 1-cycle-latency RAM read models
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            if (w_rd_en[u]) w_rd_data[u] <= wmem[w_rd_addr[u]];
            if (x_rd_en[u]) x_rd_data[u] <= xmem[x_rd_addr[u]];
        end
    end

    function automatic int ni(input int u);  return (u == 0) ? 2 : 4;  endfunction
    function automatic int ii(input int u);  return (u == 0) ? 21 : 1; endfunction
    function automatic int lat(input int u); return (u == 0) ? 21 : 3; endfunction

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        m = m * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  a;
        int   e;
        int   m;
        logic s;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = $rtoi((a - 1.0) * 8388608.0 + 0.5);
        if (m >= 8388608) begin m = 0; e++; end
        return {s, 8'(e + 127), 23'(m)};
    endfunction

    // Reference update unit: new = old - LR*delta*x with LR = 0.002
    function automatic logic [31:0] upd_f(input logic [31:0] o, input logic [31:0] x, input logic [31:0] d);
        return r2f(f2r(o) - 0.002 * f2r(d) * f2r(x));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 130)), 23'($urandom)};
    endfunction

    // Push every event a run should produce up to absolute cycle cut
    function automatic void plan_run(input int u, input int t0, input logic [9:0] b,
                                     input logic [31:0] d, input int cut);
        int          r;
        int          wc;
        int          last_wc;
        bit          all_in;
        logic [9:0]  a;
        logic [31:0] xv;
        logic [31:0] ov;
        last_wc = 0;
        all_in  = 1'b1;
        for (int k = 0; k <= ni(u); k++) begin
            r  = t0 + 1 + k * ii(u);
            a  = b + 10'(k);
            xv = (k < ni(u)) ? xmem[k] : 32'h3F80_0000;
            ov = wmem[a];
            wc = r + lat(u) + 2;
            if (r <= cut)     exp_rd.push_back('{u, r, a, (k < ni(u)), 6'(k)});
            if (r + 1 <= cut) exp_iss.push_back('{u, r + 1, ov, xv, d});
            if (wc <= cut) begin
                exp_wr.push_back('{u, wc, a, upd_f(ov, xv, d)});
                last_wc = wc;
            end else begin
                all_in = 1'b0;
            end
        end
        if (all_in && (last_wc + 1 <= cut)) exp_dn.push_back('{u, last_wc + 1});
    endfunction

    // Advance one cycle: scoreboard every DUT event, then drive the update-unit model
    task automatic tick();
        rd_t   er;
        iss_t  ei;
        wr_t   ew;
        dn_t   ed;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            if (w_rd_en[u]) begin
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_unexpected u=%0d cyc=%0d: got addr=%h, required no read", u, cyc, w_rd_addr[u]);
                end else begin
                    er = exp_rd.pop_front();
                    if (u !== er.u || cyc !== er.c || w_rd_addr[u] !== er.a || x_rd_en[u] !== er.xen ||
                        (er.xen && x_rd_addr[u] !== er.xa)) begin
                        n_fail++;
                        $display("FAIL rd u=%0d cyc=%0d addr=%h xen=%b xaddr=%h, required u=%0d cyc=%0d addr=%h xen=%b xaddr=%h",
                                 u, cyc, w_rd_addr[u], x_rd_en[u], x_rd_addr[u], er.u, er.c, er.a, er.xen, er.xa);
                    end
                end
            end else if (x_rd_en[u]) begin
                n_checks++;
                n_fail++;
                $display("FAIL x_rd_alone u=%0d cyc=%0d: got x_rd_en=1, required 0", u, cyc);
            end
            if (upd_v[u]) begin
                n_checks++;
                if (exp_iss.size() == 0) begin
                    n_fail++;
                    $display("FAIL issue_unexpected u=%0d cyc=%0d: got issue, required none", u, cyc);
                end else begin
                    ei = exp_iss.pop_front();
                    if (u !== ei.u || cyc !== ei.c || upd_old[u] !== ei.ow || upd_x[u] !== ei.xv || upd_d[u] !== ei.dv) begin
                        n_fail++;
                        $display("FAIL issue u=%0d cyc=%0d old=%h x=%h d=%h, required u=%0d cyc=%0d old=%h x=%h d=%h",
                                 u, cyc, upd_old[u], upd_x[u], upd_d[u], ei.u, ei.c, ei.ow, ei.xv, ei.dv);
                    end
                end
                pend.push_back('{u, cyc + lat(u), upd_f(upd_old[u], upd_x[u], upd_d[u])});
            end
            if (wr_en[u]) begin
                n_checks++;
                wr_cnt[u]++;
                obs_wa.push_back(wr_addr[u]);
                obs_wd.push_back(wr_data[u]);
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected u=%0d cyc=%0d: got addr=%h, required no write", u, cyc, wr_addr[u]);
                end else begin
                    ew = exp_wr.pop_front();
                    if (u !== ew.u || cyc !== ew.c || wr_addr[u] !== ew.a || wr_data[u] !== ew.dv) begin
                        n_fail++;
                        $display("FAIL wr u=%0d cyc=%0d addr=%h data=%h, required u=%0d cyc=%0d addr=%h data=%h",
                                 u, cyc, wr_addr[u], wr_data[u], ew.u, ew.c, ew.a, ew.dv);
                    end
                end
            end
            if (done[u]) begin
                n_checks++;
                done_cnt[u]++;
                if (exp_dn.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected u=%0d cyc=%0d: got done=1, required 0", u, cyc);
                end else begin
                    ed = exp_dn.pop_front();
                    if (u !== ed.u || cyc !== ed.c) begin
                        n_fail++;
                        $display("FAIL done u=%0d cyc=%0d, required u=%0d cyc=%0d", u, cyc, ed.u, ed.c);
                    end
                end
            end
        end
        for (int u = 0; u < 2; u++) begin
            res_v[u] = 1'b0;
            res_w[u] = 32'h0;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            res_v[pend[0].u] = 1'b1;
            res_w[pend[0].u] = pend[0].val;
            void'(pend.pop_front());
        end
    endtask

    // Pulse i_start for one cycle and plan the expected events; returns start cycle
    task automatic kick(input int u, input logic [9:0] b, input logic [31:0] d, input int cut_rel, output int t0);
        wr_cnt[u]   = 0;
        done_cnt[u] = 0;
        obs_wa.delete();
        obs_wd.delete();
        base_s[u]  = b;
        delta_s[u] = d;
        start_s[u] = 1'b1;
        t0 = cyc;
        plan_run(u, t0, b, d, t0 + cut_rel);
        tick();
        start_s[u] = 1'b0;
        base_s[u]  = 10'($urandom);
        delta_s[u] = rnd_f();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if ({busy[u], done[u], w_rd_en[u], x_rd_en[u], upd_v[u], wr_en[u]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_strobes u=%0d: got %b, required 000000", u,
                         {busy[u], done[u], w_rd_en[u], x_rd_en[u], upd_v[u], wr_en[u]});
            end
            n_checks++;
            if ((upd_old[u] | upd_x[u] | upd_d[u] | wr_data[u]) !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data u=%0d: got old=%h x=%h d=%h wd=%h, required 0", u,
                         upd_old[u], upd_x[u], upd_d[u], wr_data[u]);
            end
            n_checks++;
            if ({w_rd_addr[u], x_rd_addr[u], wr_addr[u]} !== 26'h0) begin
                n_fail++;
                $display("FAIL reset_addr u=%0d: got rd=%h x=%h wr=%h, required 0", u,
                         w_rd_addr[u], x_rd_addr[u], wr_addr[u]);
            end
        end
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b%b, required 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_basic();
        int t0;
        int diff;
        wmem[10'h040] = 32'h3F80_0000;
        xmem[0]       = 32'h3F00_0000;
        kick(0, 10'h040, 32'h3F80_0000, 1000, t0);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_rel1: got %b, required 1", busy[0]);
        end
        for (int i = 2; i <= 80; i++) begin
            tick();
            if (i == 30) begin
                base_s[0]  = 10'h155;
                delta_s[0] = 32'h4000_0000;
                start_s[0] = 1'b1;
            end
            if (i == 31) start_s[0] = 1'b0;
            if (i == 68) begin
                n_checks++;
                if (busy[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_rel68: got %b, required 0", busy[0]);
                end
            end
        end
        n_checks++;
        if (wr_cnt[0] !== 3 || done_cnt[0] !== 1) begin
            n_fail++;
            $display("FAIL basic_counts: got writes=%0d dones=%0d, required 3 and 1", wr_cnt[0], done_cnt[0]);
        end
        n_checks++;
        diff = (obs_wd.size() > 0) ? int'(obs_wd[0]) - int'(32'h3F7F_BE77) : 99;
        if (diff < -1 || diff > 1) begin
            n_fail++;
            $display("FAIL w0_value: got %h, required 3f7fbe77 +-1 ulp", (obs_wd.size() > 0) ? obs_wd[0] : 32'hx);
        end
        n_checks++;
        if (exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size() != 0) begin
            n_fail++;
            $display("FAIL basic_missing: got %0d expected events never seen, required 0",
                     exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size());
        end
    endtask

    task automatic test_wrap();
        int t0;
        kick(0, 10'h3FF, rnd_f(), 1000, t0);
        repeat (75) tick();
        n_checks++;
        if (obs_wa.size() != 3 || obs_wa[0] !== 10'h3FF || obs_wa[1] !== 10'h000 || obs_wa[2] !== 10'h001) begin
            n_fail++;
            $display("FAIL wrap_addrs: got %0d writes first=%h, required 3ff,000,001", obs_wa.size(),
                     (obs_wa.size() > 0) ? obs_wa[0] : 10'hx);
        end
        n_checks++;
        if (exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_missing: got %0d events never seen, required 0",
                     exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size());
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        kick(0, 10'h100, rnd_f(), 25, t0);
        for (int i = 2; i <= 75; i++) begin
            tick();
            if (i == 25) rst = 1'b1;
            if (i == 26) begin
                rst = 1'b0;
                n_checks++;
                if ({busy[0], done[0], w_rd_en[0], x_rd_en[0], upd_v[0], wr_en[0]} !== 6'b0 ||
                    upd_d[0] !== 32'h0 || wr_addr[0] !== 10'h0 || wr_data[0] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL midreset_outputs: got strobes=%b d=%h wa=%h wd=%h, required all 0",
                             {busy[0], done[0], w_rd_en[0], x_rd_en[0], upd_v[0], wr_en[0]},
                             upd_d[0], wr_addr[0], wr_data[0]);
                end
            end
        end
        n_checks++;
        if (wr_cnt[0] !== 1 || done_cnt[0] !== 0) begin
            n_fail++;
            $display("FAIL midreset_counts: got writes=%0d dones=%0d, required 1 and 0", wr_cnt[0], done_cnt[0]);
        end
        n_checks++;
        if (exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size() + pend.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_missing: got %0d events pending, required 0",
                     exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size() + pend.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        kick(1, 10'h200, rnd_f(), 1000, t0);
        repeat (25) tick();
        n_checks++;
        if (wr_cnt[1] !== 5 || done_cnt[1] !== 1 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_counts: got writes=%0d dones=%0d busy=%b, required 5, 1, 0",
                     wr_cnt[1], done_cnt[1], busy[1]);
        end
        n_checks++;
        if (exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_missing: got %0d events never seen, required 0",
                     exp_rd.size() + exp_iss.size() + exp_wr.size() + exp_dn.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u]  = 1'b0;
            base_s[u]   = 10'h0;
            delta_s[u]  = 32'h0;
            res_v[u]    = 1'b0;
            res_w[u]    = 32'h0;
            wr_cnt[u]   = 0;
            done_cnt[u] = 0;
        end
        for (int i = 0; i < 1024; i++) wmem[i] = rnd_f();
        for (int i = 0; i < 64; i++)   xmem[i] = rnd_f();
        test_reset();
        test_basic();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
